// File: rtl/mod_timer_pkg.sv
// -----------------------------------------------------------------------------
// mod_timer_pkg
// Shared definitions for the modulo timer controller slice.
//   state_e : controller state encoding, also driven out on o_state
//   DIV_W   : width of the optional prescaler divide field
// -----------------------------------------------------------------------------
package mod_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DIV_W = 8;

  // True in the states that accept a config and a start request.
  function automatic logic is_parked(input state_e s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/mod_timer_core.sv
// -----------------------------------------------------------------------------
// mod_timer_core
// Modulo-m counter register with enable and synchronous clear.
//   clk      in   clock, rising edge
//   rstn     in   synchronous active-low reset
//   i_en     in   advance the count this cycle
//   i_clr    in   force the count to 0 (wins over i_en)
//   i_mod    in   modulus m; 0 selects the full 2^WIDTH range
//   o_count  out  registered count, 0..m-1
//   o_term   out  count is at m-1, so the next advance returns it to 0
// -----------------------------------------------------------------------------
module mod_timer_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_mod,
  output logic [WIDTH-1:0] o_count,
  output logic             o_term
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_last;

  // m-1 in WIDTH bits: m=0 wraps to all-ones (full range), m=1 gives 0
  // (terminal every cycle), so no special cases are needed.
  assign w_last  = i_mod - WIDTH'(1);
  assign o_term  = (r_count == w_last);
  assign o_count = r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, regardless of block order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_term ? '0 : r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mod_timer_ctrl.sv
// -----------------------------------------------------------------------------
// mod_timer_ctrl
// Sequencing controller for a programmable modulo counter. A config
// (modulus, wrap repeat count, mode) is accepted over a valid/ready
// handshake; start/pause/abort drive the run, and wrap/done pulses mark
// the count returning to 0 and one-shot completion.
//
// Optional feature: define MOD_TIMER_PRESCALE_EN to add i_cfg_div, a
// prescaler that advances the count once every cfg_div+1 RUN cycles.
//
// Ports:
//   clk             in   clock, rising edge
//   rstn            in   synchronous active-low reset
//   i_cfg_valid     in   config offered
//   o_cfg_ready     out  config accepted when valid & ready (IDLE/DONE)
//   i_cfg_mod       in   modulus (0 => 2^WIDTH)
//   i_cfg_reps      in   wraps before done in one-shot mode (0 => 1)
//   i_cfg_periodic  in   1 = run forever, never done
//   i_cfg_div       in   prescale divide (MOD_TIMER_PRESCALE_EN only)
//   i_start         in   begin a run from IDLE/DONE
//   i_pause         in   level, freeze the count while high
//   i_abort         in   return to IDLE without done
//   o_count         out  current count
//   o_wrap          out  1-cycle pulse, count returned to 0
//   o_done          out  1-cycle pulse, one-shot run complete
//   o_busy          out  state is RUN or HOLD
//   o_state         out  IDLE=0 RUN=1 HOLD=2 DONE=3
// -----------------------------------------------------------------------------
module mod_timer_ctrl
  import mod_timer_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DEF_MOD = 15,
  parameter int REP_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [WIDTH-1:0] i_cfg_mod,
  input  logic [REP_W-1:0] i_cfg_reps,
  input  logic             i_cfg_periodic,
`ifdef MOD_TIMER_PRESCALE_EN
  input  logic [DIV_W-1:0] i_cfg_div,
`endif
  input  logic             i_start,
  input  logic             i_pause,
  input  logic             i_abort,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap,
  output logic             o_done,
  output logic             o_busy,
  output logic [1:0]       o_state
);

  state_e           r_state;
  logic [WIDTH-1:0] r_mod;
  logic [REP_W-1:0] r_reps;
  logic             r_periodic;
  logic [REP_W-1:0] r_wrap_cnt;
  logic             r_wrap;
  logic             r_done;
  logic             r_busy;
  logic             r_cfg_ready;

  logic             w_cfg_hs;
  logic             w_launch;
  logic             w_clr;
  logic             w_active;
  logic             w_tick;
  logic             w_en;
  logic             w_term;
  logic [REP_W-1:0] w_reps_last;

  assign w_cfg_hs    = i_cfg_valid && r_cfg_ready;
  assign w_launch    = is_parked(r_state) && i_start && !i_abort;
  assign w_clr       = i_abort || w_launch;
  // A RUN cycle that is neither aborted nor pausing advances the prescaler.
  assign w_active    = (r_state == ST_RUN) && !i_abort && !i_pause;
  assign w_en        = w_active && w_tick;
  // Index of the final wrap; reps=0 is treated as a single wrap.
  assign w_reps_last = (r_reps == '0) ? '0 : r_reps - REP_W'(1);

`ifdef MOD_TIMER_PRESCALE_EN
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_pre;

  assign w_tick = (r_pre == r_div);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_div <= '0;
      r_pre <= '0;
    end else begin
      if (w_cfg_hs) r_div <= i_cfg_div;
      if (w_clr) begin
        r_pre <= '0;
      end else if (w_active) begin
        r_pre <= w_tick ? '0 : r_pre + DIV_W'(1);
      end
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  mod_timer_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .rstn    (rstn),
    .i_en    (w_en),
    .i_clr   (w_clr),
    .i_mod   (r_mod),
    .o_count (o_count),
    .o_term  (w_term)
  );

  // FSM, config store and wrap counter. busy/cfg_ready are registered
  // alongside the state so they always describe the state being entered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: config registers are reset to defaults too, so a mid-run reset
      // leaves no stale modulus or mode behind.
      r_state     <= ST_IDLE;
      r_mod       <= WIDTH'(DEF_MOD);
      r_reps      <= REP_W'(1);
      r_periodic  <= 1'b0;
      r_wrap_cnt  <= '0;
      r_wrap      <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else begin
      r_wrap <= 1'b0;
      r_done <= 1'b0;

      if (w_cfg_hs) begin
        r_mod      <= i_cfg_mod;
        r_reps     <= i_cfg_reps;
        r_periodic <= i_cfg_periodic;
      end

      if (i_abort) begin
        r_state     <= ST_IDLE;
        r_busy      <= 1'b0;
        r_cfg_ready <= 1'b1;
      end else begin
        unique case (r_state)
          ST_IDLE, ST_DONE: begin
            if (i_start) begin
              r_state     <= ST_RUN;
              r_wrap_cnt  <= '0;
              r_busy      <= 1'b1;
              r_cfg_ready <= 1'b0;
            end
          end
          ST_RUN: begin
            if (i_pause) begin
              r_state <= ST_HOLD;
            end else if (w_en && w_term) begin
              r_wrap <= 1'b1;
              if (r_periodic) begin
                if (r_wrap_cnt != '1) r_wrap_cnt <= r_wrap_cnt + REP_W'(1);
              end else if (r_wrap_cnt == w_reps_last) begin
                r_state     <= ST_DONE;
                r_done      <= 1'b1;
                r_busy      <= 1'b0;
                r_cfg_ready <= 1'b1;
              end else begin
                r_wrap_cnt <= r_wrap_cnt + REP_W'(1);
              end
            end
          end
          ST_HOLD: begin
            // Release only re-enters RUN; the count moves on the cycle after.
            if (!i_pause) r_state <= ST_RUN;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_state     = r_state;
  assign o_wrap      = r_wrap;
  assign o_done      = r_done;
  assign o_busy      = r_busy;
  assign o_cfg_ready = r_cfg_ready;

endmodule
